call_scheduler: RTL and testbench
=================================

# call_scheduler

Request bookkeeping and direction arbiter for the elevator car. It latches hall calls (up/down) and car-panel calls on button press edges and clears them when the car services a floor. It runs a LOOK-style direction state machine, and tells the elevator FSM which way to travel next and whether to halt at the current floor. It sits between the raw button inputs and the FSM inside the top-level status-transition wrapper, replacing direct wiring of raw inputs into the FSM.

## Interface
Parameters:
- FLOORS, 8, number of floors; bit i of every call vector is floor i.
- FW, 3, floor index width; FLOORS ≤ 2**FW.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- upcall_input  input  FLOORS  raw hall up buttons, level, active-high.
- downcall_input  input  FLOORS  raw hall down buttons, level, active-high.
- floor_btn_input  input  FLOORS  raw car-panel buttons, level, active-high.
- floor  input  FW  current car floor from the FSM.
- arrive  input  1  one-cycle pulse from the FSM: car stopped at `floor` and doors are opening.
- upcall  output  FLOORS  latched up calls.
- downcall  output  FLOORS  latched down calls.
- floor_btn  output  FLOORS  latched car calls.
- nextup  output  1  direction state is UP.
- nextdown  output  1  direction state is DOWN.
- stop_here  output  1  the car must halt at `floor` in the current direction.
- pending  output  1  any latched request.

## Operation
- Edge detect: each raw input has a previous-value register. A bit sets its latch when raw=1 and prev=0.
- Forced-zero bits: upcall[FLOORS-1] and downcall[0] are always 0. Presses on those bits are ignored.
- Derived terms, combinational from the latches and `floor`:
  - req = upcall|downcall|floor_btn.
  - above = any req bit with index > floor.
  - below = any req bit with index < floor.
- Direction FSM, states IDLE/UP/DOWN:
  - IDLE: above → UP; else below → DOWN; else stay IDLE.
  - UP: above → stay UP; else below → DOWN; else IDLE.
  - DOWN: below → stay DOWN; else above → UP; else IDLE.
- stop_here:
  - UP: floor_btn[f] | upcall[f] | (!above & downcall[f]).
  - DOWN: floor_btn[f] | downcall[f] | (!below & upcall[f]).
  - IDLE: req[f].
- Clear on arrive, for f = floor:
  - Always clear floor_btn[f].
  - UP: clear upcall[f]. Also clear downcall[f] if !above.
  - DOWN: clear downcall[f]. Also clear upcall[f] if !below.
  - IDLE: clear both hall bits at f.
- Set and clear of the same bit in the same cycle: clear wins. A press at the served floor while the doors open is absorbed.
- pending = |req.
- nextup/nextdown are decoded from the state register. They are never both 1.
- `floor` ≥ FLOORS: no clear occurs; above/below use numeric compare.

## Timing
- Reset (rst=0, asynchronous): all latches, prev registers, and outputs go to 0; state goes to IDLE.
- A press edge sampled at clock edge k makes the latch bit visible after edge k (1-cycle latency).
- State updates at edge k+1 from the latches visible after edge k. nextup/nextdown change after edge k+1.
- stop_here and pending are combinational from the latches, state and `floor`. They have no added latency.
- A clear on arrive sampled at edge k takes effect after edge k. The direction reevaluates at edge k+1.
- A held button re-latches only after release and a fresh press.

## Configuration
- CAR_CALL_CANCEL_EN defined: a new press edge on a floor_btn bit that is already latched clears that bit (toggle). Clear-by-arrive is unchanged.
- CAR_CALL_CANCEL_EN undefined: repeated presses are ignored while the bit is latched.
- Hall calls never toggle in either build.

## Structure
- Shared package elevator_pkg:
  - dir_t enum: DIR_IDLE=2'b00, DIR_UP=2'b01, DIR_DOWN=2'b10.
  - FLOORS_DEFAULT=8 and FW_DEFAULT=3.
- Sub-module call_latch holds the per-vector logic: prev register, edge detect, set/clear with clear priority, and an optional toggle port. It is instantiated three times; the toggle is enabled only for floor_btn under CAR_CALL_CANCEL_EN.

## Test plan
- Reset check: rst=0 mid-run with calls latched → all vectors 0, nextup=nextdown=0, pending=0 immediately, without waiting for a clock edge.
- Single call: floor=0, press floor_btn_input[5] for 1 cycle → floor_btn=8'h20 the next cycle, nextup=1 one cycle later, stop_here=0 until floor=5. arrive at floor 5 → floor_btn=0, state returns to IDLE.
- Pass-by rule: floor=2, state UP, downcall[4]=1 and floor_btn[6]=1. At floor=4, stop_here=0. At floor=6 with arrive, state goes to DOWN and stop_here=1 when floor=4.
- Reversal clear: state UP, floor=7, only downcall[7]... (invalid) → instead use upcall[3]=downcall[3]=1, floor=3, nothing above. arrive clears both bits; state goes to IDLE.
- Forced-zero bits: press upcall_input[7] and downcall_input[0] → upcall[7]=downcall[0]=0, pending=0.
- Toggle: press floor_btn_input[2] twice with release between. With CAR_CALL_CANCEL_EN, floor_btn[2] ends at 0; without it, floor_btn[2] ends at 1. A held press re-latches nothing.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared elevator types: travel-direction encoding and default geometry.
package elevator_pkg;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_t;

    localparam int FLOORS_DEFAULT = 8;
    localparam int FW_DEFAULT     = 3;

endpackage

// File: rtl/call_scheduler_if.sv
// Button/request bus between the car controller and the call scheduler.
// master: drives raw buttons, floor and arrive; slave: the scheduler.
interface call_scheduler_if
    import elevator_pkg::*;
#(
    parameter int FLOORS = FLOORS_DEFAULT,
    parameter int FW     = FW_DEFAULT
);

    logic [FLOORS-1:0] upcall_input;
    logic [FLOORS-1:0] downcall_input;
    logic [FLOORS-1:0] floor_btn_input;
    logic [FW-1:0]     floor;
    logic              arrive;
    logic [FLOORS-1:0] upcall;
    logic [FLOORS-1:0] downcall;
    logic [FLOORS-1:0] floor_btn;
    logic              nextup;
    logic              nextdown;
    logic              stop_here;
    logic              pending;

    modport master (
        output upcall_input, downcall_input, floor_btn_input, floor, arrive,
        input  upcall, downcall, floor_btn, nextup, nextdown, stop_here, pending
    );

    modport slave (
        input  upcall_input, downcall_input, floor_btn_input, floor, arrive,
        output upcall, downcall, floor_btn, nextup, nextdown, stop_here, pending
    );

endinterface

// File: rtl/call_latch.sv
// Per-vector call latch: press-edge detection on a raw level input, set on
// edge (or toggle when TOGGLE_EN), clear has priority over set. Bits outside
// MASK can never latch.
module call_latch #(
    parameter int                FLOORS    = 8,
    parameter logic [FLOORS-1:0] MASK      = '1,
    parameter bit                TOGGLE_EN = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLOORS-1:0] raw_i,
    input  logic [FLOORS-1:0] clr_i,
    output logic [FLOORS-1:0] lat_o
);

    logic [FLOORS-1:0] prev_q;
    logic [FLOORS-1:0] lat_q;
    logic [FLOORS-1:0] lat_d;
    logic [FLOORS-1:0] press_w;

    // Next latch value: rising edges set (or toggle), clears always win.
    always_comb begin
        press_w = raw_i & ~prev_q & MASK;
        if (TOGGLE_EN) begin
            lat_d = (lat_q ^ press_w) & ~clr_i;
        end else begin
            lat_d = (lat_q | press_w) & ~clr_i;
        end
    end

    // Previous-level and latch registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= '0;
            lat_q  <= '0;
        end else begin
            prev_q <= raw_i;
            lat_q  <= lat_d;
        end
    end

    assign lat_o = lat_q;

endmodule

// File: rtl/call_scheduler.sv
// Call bookkeeping and LOOK-style direction arbiter for the elevator car.
// Optional feature macro: CAR_CALL_CANCEL_EN -- a fresh press on an already
// latched car-panel call cancels it. Hall calls never toggle.
module call_scheduler
    import elevator_pkg::*;
#(
    parameter int FLOORS = FLOORS_DEFAULT,
    parameter int FW     = FW_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    call_scheduler_if.slave bus
);

    // Top-floor up call and bottom-floor down call do not exist.
    localparam logic [FLOORS-1:0] UP_MASK = ~(FLOORS'(1) << (FLOORS - 1));
    localparam logic [FLOORS-1:0] DN_MASK = ~FLOORS'(1);
`ifdef CAR_CALL_CANCEL_EN
    localparam bit FB_TOGGLE = 1'b1;
`else
    localparam bit FB_TOGGLE = 1'b0;
`endif

    dir_t              state_q;
    dir_t              state_d;
    logic [FLOORS-1:0] up_lat;
    logic [FLOORS-1:0] dn_lat;
    logic [FLOORS-1:0] fb_lat;
    logic [FLOORS-1:0] req;
    logic [FLOORS-1:0] sel;
    logic [FLOORS-1:0] hit;
    logic [FLOORS-1:0] clr_up;
    logic [FLOORS-1:0] clr_dn;
    logic [FLOORS-1:0] clr_fb;
    logic [FW-1:0]     floor_w;
    logic              above;
    logic              below;
    logic              up_f;
    logic              dn_f;
    logic              fb_f;
    logic              stop_w;

    assign floor_w = bus.floor;

    call_latch #(.FLOORS(FLOORS), .MASK(UP_MASK), .TOGGLE_EN(1'b0)) u_up (
        .clk(clk), .rst(rst), .raw_i(bus.upcall_input), .clr_i(clr_up), .lat_o(up_lat)
    );

    call_latch #(.FLOORS(FLOORS), .MASK(DN_MASK), .TOGGLE_EN(1'b0)) u_dn (
        .clk(clk), .rst(rst), .raw_i(bus.downcall_input), .clr_i(clr_dn), .lat_o(dn_lat)
    );

    call_latch #(.FLOORS(FLOORS), .MASK('1), .TOGGLE_EN(FB_TOGGLE)) u_fb (
        .clk(clk), .rst(rst), .raw_i(bus.floor_btn_input), .clr_i(clr_fb), .lat_o(fb_lat)
    );

    // Requests above/below the car; out-of-range floors select nothing.
    always_comb begin
        req   = up_lat | dn_lat | fb_lat;
        above = 1'b0;
        below = 1'b0;
        sel   = '0;
        for (int i = 0; i < FLOORS; i++) begin
            if (i > int'(floor_w)) above = above | req[i];
            if (i < int'(floor_w)) below = below | req[i];
            sel[i] = (i == int'(floor_w));
        end
        up_f = |(up_lat & sel);
        dn_f = |(dn_lat & sel);
        fb_f = |(fb_lat & sel);
    end

    // Halt decision and arrive clears, both depending on travel direction.
    always_comb begin
        hit    = bus.arrive ? sel : '0;
        clr_fb = hit;
        clr_up = hit;
        clr_dn = hit;
        stop_w = fb_f | up_f | dn_f;
        case (state_q)
            DIR_UP: begin
                stop_w = fb_f | up_f | (!above & dn_f);
                clr_dn = above ? '0 : hit;
            end
            DIR_DOWN: begin
                stop_w = fb_f | dn_f | (!below & up_f);
                clr_up = below ? '0 : hit;
            end
            default: ;
        endcase
    end

    // Direction next state: keep going while work remains ahead, else reverse.
    always_comb begin
        state_d = state_q;
        case (state_q)
            DIR_UP:   state_d = above ? DIR_UP   : (below ? DIR_DOWN : DIR_IDLE);
            DIR_DOWN: state_d = below ? DIR_DOWN : (above ? DIR_UP   : DIR_IDLE);
            default:  state_d = above ? DIR_UP   : (below ? DIR_DOWN : DIR_IDLE);
        endcase
    end

    // Direction state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DIR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.upcall    = up_lat;
    assign bus.downcall  = dn_lat;
    assign bus.floor_btn = fb_lat;
    assign bus.nextup    = (state_q == DIR_UP);
    assign bus.nextdown  = (state_q == DIR_DOWN);
    assign bus.stop_here = stop_w;
    assign bus.pending   = |req;

endmodule

// File: tb/tb_call_scheduler.sv
// Self-checking bench for call_scheduler: directed scenarios plus randomized
// traffic compared against a request-list reference model.
module tb_call_scheduler;

`ifdef CAR_CALL_CANCEL_EN
    localparam bit CANCEL = 1'b1;
`else
    localparam bit CANCEL = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    call_scheduler_if #(.FLOORS(8), .FW(3)) bus ();

    call_scheduler #(.FLOORS(8), .FW(3)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: outstanding request lists and travel direction
    // (0 = idle, 1 = up, 2 = down), plus last seen raw button levels.
    logic [7:0] m_up, m_dn, m_fb;
    logic [7:0] p_up, p_dn, p_fb;
    int         m_dir;

    function automatic logic [7:0] m_req();
        return m_up | m_dn | m_fb;
    endfunction

    function automatic bit m_above();
        logic [7:0] r;
        r = m_req();
        for (int i = 0; i < 8; i++) if (r[i] && i > int'(bus.floor)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_below();
        logic [7:0] r;
        r = m_req();
        for (int i = 0; i < 8; i++) if (r[i] && i < int'(bus.floor)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_stop();
        int f;
        f = int'(bus.floor);
        if (m_dir == 1) return m_fb[f] | m_up[f] | (!m_above() & m_dn[f]);
        if (m_dir == 2) return m_fb[f] | m_dn[f] | (!m_below() & m_up[f]);
        return m_fb[f] | m_up[f] | m_dn[f];
    endfunction

    function automatic logic [27:0] m_out();
        return {m_up, m_dn, m_fb, (m_dir == 1), (m_dir == 2), m_stop(), |m_req()};
    endfunction

    function automatic logic [27:0] dut_out();
        return {bus.upcall, bus.downcall, bus.floor_btn, bus.nextup, bus.nextdown,
                bus.stop_here, bus.pending};
    endfunction

    task automatic m_clear();
        m_up = '0; m_dn = '0; m_fb = '0;
        p_up = '0; p_dn = '0; p_fb = '0;
        m_dir = 0;
    endtask

    // One clock: model advances from the inputs present at the edge.
    task automatic step();
        int         nd;
        int         f;
        bit         a, b;
        logic [7:0] nu, ndn, nf, eu, ed, ef;
        a = m_above();
        b = m_below();
        if (m_dir == 2) nd = b ? 2 : (a ? 1 : 0);
        else            nd = a ? 1 : (b ? 2 : 0);
        eu  = bus.upcall_input    & ~p_up & 8'h7F;
        ed  = bus.downcall_input  & ~p_dn & 8'hFE;
        ef  = bus.floor_btn_input & ~p_fb;
        nu  = m_up | eu;
        ndn = m_dn | ed;
        nf  = CANCEL ? (m_fb ^ ef) : (m_fb | ef);
        if (bus.arrive) begin
            f = int'(bus.floor);
            nf[f] = 1'b0;
            if (m_dir == 1) begin
                nu[f] = 1'b0;
                if (!a) ndn[f] = 1'b0;
            end else if (m_dir == 2) begin
                ndn[f] = 1'b0;
                if (!b) nu[f] = 1'b0;
            end else begin
                nu[f]  = 1'b0;
                ndn[f] = 1'b0;
            end
        end
        @(posedge clk);
        p_up = bus.upcall_input;
        p_dn = bus.downcall_input;
        p_fb = bus.floor_btn_input;
        m_up = nu; m_dn = ndn; m_fb = nf; m_dir = nd;
        #1;
    endtask

    task automatic idle_inputs();
        bus.upcall_input    = '0;
        bus.downcall_input  = '0;
        bus.floor_btn_input = '0;
        bus.arrive          = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        m_clear();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        bus.floor = 3'd0;
        bus.upcall_input = 8'h04;
        bus.floor_btn_input = 8'h20;
        step();
        idle_inputs();
        step();
        n_cmp++;
        if (dut_out() !== m_out()) begin
            n_fail++;
            $display("FAIL reset_precalls: got %h want %h", dut_out(), m_out());
        end
        #2;
        rst = 1'b0;
        m_clear();
        #1;
        n_cmp++;
        if (dut_out() !== 28'h0) begin
            n_fail++;
            $display("FAIL reset_async: got %h want %h", dut_out(), 28'h0);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single_call();
        do_reset();
        bus.floor = 3'd0;
        bus.floor_btn_input = 8'h20;
        step();
        idle_inputs();
        n_cmp++;
        if (bus.floor_btn !== 8'h20 || bus.nextup !== 1'b0) begin
            n_fail++;
            $display("FAIL single_latch: got fb=%h up=%b want fb=20 up=0", bus.floor_btn, bus.nextup);
        end
        step();
        n_cmp++;
        if (bus.nextup !== 1'b1) begin
            n_fail++;
            $display("FAIL single_dir: got nextup=%b want 1", bus.nextup);
        end
        for (int fl = 0; fl < 5; fl++) begin
            bus.floor = 3'(fl);
            #1;
            n_cmp++;
            if (bus.stop_here !== 1'b0) begin
                n_fail++;
                $display("FAIL single_nostop floor=%0d: got %b want 0", fl, bus.stop_here);
            end
        end
        bus.floor = 3'd5;
        #1;
        n_cmp++;
        if (bus.stop_here !== 1'b1) begin
            n_fail++;
            $display("FAIL single_stop: got %b want 1", bus.stop_here);
        end
        bus.arrive = 1'b1;
        step();
        bus.arrive = 1'b0;
        step();
        n_cmp++;
        if (bus.floor_btn !== 8'h00 || bus.nextup !== 1'b0 || bus.nextdown !== 1'b0) begin
            n_fail++;
            $display("FAIL single_clear: got fb=%h up=%b dn=%b want 00 0 0",
                     bus.floor_btn, bus.nextup, bus.nextdown);
        end
    endtask

    task automatic test_pass_by();
        do_reset();
        bus.floor = 3'd2;
        bus.downcall_input  = 8'h10;
        bus.floor_btn_input = 8'h40;
        step();
        idle_inputs();
        step();
        bus.floor = 3'd4;
        #1;
        n_cmp++;
        if (bus.nextup !== 1'b1 || bus.stop_here !== 1'b0) begin
            n_fail++;
            $display("FAIL passby_skip: got up=%b stop=%b want 1 0", bus.nextup, bus.stop_here);
        end
        bus.floor = 3'd6;
        #1;
        n_cmp++;
        if (bus.stop_here !== 1'b1) begin
            n_fail++;
            $display("FAIL passby_top: got stop=%b want 1", bus.stop_here);
        end
        bus.arrive = 1'b1;
        step();
        bus.arrive = 1'b0;
        n_cmp++;
        if (bus.nextdown !== 1'b1 || bus.downcall !== 8'h10 || bus.floor_btn !== 8'h00) begin
            n_fail++;
            $display("FAIL passby_rev: got dn=%b dc=%h fb=%h want 1 10 00",
                     bus.nextdown, bus.downcall, bus.floor_btn);
        end
        bus.floor = 3'd4;
        #1;
        n_cmp++;
        if (bus.stop_here !== 1'b1) begin
            n_fail++;
            $display("FAIL passby_down_stop: got %b want 1", bus.stop_here);
        end
    endtask

    task automatic test_reversal_clear();
        do_reset();
        bus.floor = 3'd0;
        bus.upcall_input   = 8'h08;
        bus.downcall_input = 8'h08;
        step();
        idle_inputs();
        step();
        bus.floor = 3'd3;
        #1;
        n_cmp++;
        if (bus.nextup !== 1'b1 || bus.stop_here !== 1'b1) begin
            n_fail++;
            $display("FAIL rev_pre: got up=%b stop=%b want 1 1", bus.nextup, bus.stop_here);
        end
        bus.arrive = 1'b1;
        step();
        bus.arrive = 1'b0;
        n_cmp++;
        if (bus.upcall !== 8'h00 || bus.downcall !== 8'h00 || bus.pending !== 1'b0) begin
            n_fail++;
            $display("FAIL rev_clear: got uc=%h dc=%h pend=%b want 00 00 0",
                     bus.upcall, bus.downcall, bus.pending);
        end
        step();
        n_cmp++;
        if (bus.nextup !== 1'b0 || bus.nextdown !== 1'b0) begin
            n_fail++;
            $display("FAIL rev_idle: got up=%b dn=%b want 0 0", bus.nextup, bus.nextdown);
        end
    endtask

    task automatic test_forced_zero();
        do_reset();
        bus.floor = 3'd4;
        bus.upcall_input   = 8'h80;
        bus.downcall_input = 8'h01;
        step();
        idle_inputs();
        step();
        n_cmp++;
        if (bus.upcall !== 8'h00 || bus.downcall !== 8'h00 || bus.pending !== 1'b0
            || bus.nextup !== 1'b0 || bus.nextdown !== 1'b0) begin
            n_fail++;
            $display("FAIL forced_zero: got uc=%h dc=%h pend=%b want 00 00 0",
                     bus.upcall, bus.downcall, bus.pending);
        end
    endtask

    task automatic test_toggle();
        logic exp_bit;
        exp_bit = CANCEL ? 1'b0 : 1'b1;
        do_reset();
        bus.floor = 3'd0;
        bus.floor_btn_input = 8'h04;
        step();
        bus.floor_btn_input = 8'h00;
        step();
        bus.floor_btn_input = 8'h04;
        step();
        bus.floor_btn_input = 8'h00;
        step();
        n_cmp++;
        if (bus.floor_btn[2] !== exp_bit) begin
            n_fail++;
            $display("FAIL toggle_twice: got %b want %b", bus.floor_btn[2], exp_bit);
        end
        bus.floor_btn_input = 8'h02;
        repeat (4) step();
        bus.floor_btn_input = 8'h00;
        step();
        n_cmp++;
        if (bus.floor_btn[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL toggle_held: got %b want 1", bus.floor_btn[1]);
        end
    endtask

    task automatic test_random();
        logic [7:0] u, d, c;
        do_reset();
        bus.floor = 3'd0;
        for (int n = 0; n < 600; n++) begin
            u = '0; d = '0; c = '0;
            for (int i = 0; i < 8; i++) begin
                u[i] = ($urandom_range(0, 5) == 0);
                d[i] = ($urandom_range(0, 5) == 0);
                c[i] = ($urandom_range(0, 4) == 0);
            end
            bus.upcall_input    = u;
            bus.downcall_input  = d;
            bus.floor_btn_input = c;
            bus.floor  = 3'($urandom_range(0, 7));
            bus.arrive = ($urandom_range(0, 2) == 0);
            #1;
            n_cmp++;
            if (dut_out() !== m_out()) begin
                n_fail++;
                $display("FAIL rand_comb n=%0d: got %h want %h", n, dut_out(), m_out());
            end
            step();
            n_cmp++;
            if (dut_out() !== m_out()) begin
                n_fail++;
                $display("FAIL rand_seq n=%0d: got %h want %h", n, dut_out(), m_out());
            end
        end
        idle_inputs();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b0;
        bus.floor = 3'd0;
        idle_inputs();
        m_clear();
        #2;
        n_cmp++;
        if (dut_out() !== 28'h0) begin
            n_fail++;
            $display("FAIL power_on_reset: got %h want %h", dut_out(), 28'h0);
        end
        test_reset();
        test_single_call();
        test_pass_by();
        test_reversal_clear();
        test_forced_zero();
        test_toggle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
